// File: rtl/ddr_bridge_rr_arbiter.sv
// Round-robin arbiter sharing the single AXI4 slave port of the DDR bridge; one burst in flight at a time.
// Optional watchdog enabled by defining DDR_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; arbitrate among req_valid starting after the last winner
// ISSUE | AW or AR valid with latched payload, waiting for the bridge's ready
// WAIT  | address accepted; waiting for B handshake (write) or last R beat (read)

module ddr_bridge_rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 27,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          axi_aclk,
  input  logic                          axi_resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*8-1:0]          req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [ADDR_WIDTH-1:0]         axi_awaddr,
  output logic [7:0]                    axi_awlen,
  output logic                          axi_awvalid,
  input  logic                          axi_awready,
  output logic [ADDR_WIDTH-1:0]         axi_araddr,
  output logic [7:0]                    axi_arlen,
  output logic                          axi_arvalid,
  input  logic                          axi_arready,
  input  logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic                          axi_rvalid,
  input  logic                          axi_rready,
  input  logic                          axi_rlast,
  output logic                          timeout_err
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic                    wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [NUM_REQ-1:0]      done_q, done_d;
  logic                    awvalid_q, awvalid_d;
  logic                    arvalid_q, arvalid_d;

  logic                    win_found;
  logic [IDXW-1:0]         win_idx;
  logic [IDXW-1:0]         cand;
  logic                    burst_done;
  logic                    addr_hs;

`ifdef DDR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    timeout_q, timeout_d;
`endif

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDXW'((int'(ptr_q) + off) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign addr_hs    = (awvalid_q && axi_awready) || (arvalid_q && axi_arready);
  assign burst_done = (state_q == ST_WAIT) &&
                      (wr_q ? (axi_bvalid && axi_bready)
                            : (axi_rvalid && axi_rready && axi_rlast));

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    len_d       = len_q;
    req_ready_d = '0;
    gnt_d       = gnt_q;
    done_d      = '0;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
`ifdef DDR_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d     = ST_ISSUE;
          ptr_d       = win_idx;
          wr_d        = req_wr[win_idx];
          addr_d      = req_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          len_d       = req_len[int'(win_idx)*8 +: 8];
          req_ready_d = ONE << win_idx;
          gnt_d       = ONE << win_idx;
          awvalid_d   = req_wr[win_idx];
          arvalid_d   = !req_wr[win_idx];
`ifdef DDR_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (addr_hs) begin
          awvalid_d = 1'b0;
          arvalid_d = 1'b0;
          state_d   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (burst_done) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          done_d  = gnt_q;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        awvalid_d = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase

`ifdef DDR_ARB_TIMEOUT_EN
    // Fires on the edge where the count would reach TIMEOUT_CYCLES-1.
    if ((state_q == ST_ISSUE || state_q == ST_WAIT) && !burst_done) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        done_d    = gnt_q;
        timeout_d = 1'b1;
        awvalid_d = 1'b0;
        arvalid_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDXW'(NUM_REQ - 1);
      wr_q        <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      req_ready_q <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      req_ready_q <= req_ready_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
`ifdef DDR_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign axi_awaddr  = addr_q;
  assign axi_awlen   = len_q;
  assign axi_awvalid = awvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = len_q;
  assign axi_arvalid = arvalid_q;

`ifdef DDR_ARB_TIMEOUT_EN
  assign timeout_err = timeout_q;
`else
  assign timeout_err = 1'b0;
`endif

  param_range: assert property (@(posedge axi_aclk)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TIMEOUT_CYCLES >= 2));
  gnt_onehot: assert property (@(posedge axi_aclk) disable iff (!axi_resetn)
    $onehot0(gnt_q));
  addr_excl: assert property (@(posedge axi_aclk) disable iff (!axi_resetn)
    !(awvalid_q && arvalid_q));

endmodule

// File: tb/tb_ddr_bridge_rr_arbiter.sv
// Scoreboard bench for ddr_bridge_rr_arbiter: directed requests, simple bridge responder, decoupled monitor.
// The watchdog scenario runs only when DDR_ARB_TIMEOUT_EN is defined.
module tb_ddr_bridge_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 27;
`ifdef DDR_ARB_TIMEOUT_EN
  localparam int TO = 64;
`else
  localparam int TO = 4096;
`endif
  localparam logic [N-1:0] ONE = 1;

  logic           clk, resetn;
  logic [N-1:0]   req_valid, req_wr, req_ready, gnt, done;
  logic [N*AW-1:0] req_addr;
  logic [N*8-1:0] req_len;
  logic [AW-1:0]  axi_awaddr, axi_araddr;
  logic [7:0]     axi_awlen, axi_arlen;
  logic           axi_awvalid, axi_awready, axi_arvalid, axi_arready;
  logic           axi_bvalid, axi_bready, axi_rvalid, axi_rready, axi_rlast;
  logic           timeout_err;

  ddr_bridge_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .axi_aclk(clk), .axi_resetn(resetn),
    .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
    .req_ready(req_ready), .gnt(gnt), .done(done),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    bit          wr;
    logic [AW-1:0] addr;
    logic [7:0]  len;
  } txn_t;

  txn_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // requester payload tables
  bit            p_wr[N];
  logic [AW-1:0] p_addr[N];
  logic [7:0]    p_len[N];
  int            pend[N];

  // responder knobs
  int aw_lat, ar_lat, b_lat;
  bit stray, no_b, slave_final, s_wr;
  int s_len;

  // monitor state
  bit            busy, done_pending, expect_to;
  int            owner, cyc, hs_cyc;
  bit            prev_awv, prev_awr, prev_arv, prev_arr;
  logic [AW-1:0] prev_awaddr, prev_araddr;
  logic [7:0]    prev_awlen, prev_arlen;
  logic [N-1:0]  exp_done;
  bit            exp_to;
  txn_t          t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input bit wr, input int addr, input int len);
    txn_t x;
    x.idx = idx; x.wr = wr; x.addr = AW'(addr); x.len = 8'(len);
    exp_q.push_back(x);
  endtask

  function automatic bit all_idle();
    bit r = (exp_q.size() == 0) && !busy && (gnt == '0);
    for (int i = 0; i < N; i++) if (pend[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (k < budget && !all_idle()) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL %s_complete: still busy after %0d cycles, %0d bursts outstanding", name, budget, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Requesters: hold valid until the accept pulse, then advance address for the next burst.
  initial begin
    req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (req_ready[i] === 1'b1 && pend[i] > 0) begin
          pend[i]--;
          p_addr[i] = p_addr[i] + AW'('h40);
        end
        req_valid[i]          = (pend[i] > 0);
        req_wr[i]             = p_wr[i];
        req_addr[i*AW +: AW]  = p_addr[i];
        req_len[i*8 +: 8]     = p_len[i];
      end
    end
  end

  // Bridge responder: ready after a latency, then B or len+1 R beats.
  initial begin
    axi_awready = 0; axi_arready = 0; axi_bvalid = 0; axi_bready = 0;
    axi_rvalid = 0; axi_rready = 0; axi_rlast = 0; slave_final = 0;
    forever begin
      @(posedge clk); #1;
      if (axi_awvalid === 1'b1 || axi_arvalid === 1'b1) begin
        s_wr  = axi_awvalid;
        s_len = s_wr ? int'(axi_awlen) : int'(axi_arlen);
        for (int k = 0; k < (s_wr ? aw_lat : ar_lat); k++) begin
          if (stray && k == 2) begin
            axi_bvalid = 1; axi_bready = 1; axi_rvalid = 1; axi_rready = 1; axi_rlast = 1;
          end
          @(posedge clk); #1;
          axi_bvalid = 0; axi_bready = 0; axi_rvalid = 0; axi_rready = 0; axi_rlast = 0;
        end
        if (s_wr) axi_awready = 1; else axi_arready = 1;
        @(posedge clk); #1;
        axi_awready = 0; axi_arready = 0;
        if (s_wr) begin
          if (!no_b) begin
            for (int k = 0; k < b_lat; k++) begin @(posedge clk); #1; end
            axi_bvalid = 1; axi_bready = 1; slave_final = 1;
            @(posedge clk); #1;
            axi_bvalid = 0; axi_bready = 0; slave_final = 0;
          end
        end else begin
          for (int b = 0; b <= s_len; b++) begin
            axi_rvalid = 1; axi_rready = 1; axi_rlast = (b == s_len); slave_final = (b == s_len);
            @(posedge clk); #1;
          end
          axi_rvalid = 0; axi_rready = 0; axi_rlast = 0; slave_final = 0;
        end
      end
    end
  end

  // Monitor: pops the expected burst on each address handshake and checks done/timeout timing.
  initial begin
    cyc = 0; busy = 0; done_pending = 0; owner = 0; hs_cyc = 0;
    prev_awv = 0; prev_awr = 0; prev_arv = 0; prev_arr = 0;
    prev_awaddr = '0; prev_araddr = '0; prev_awlen = '0; prev_arlen = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn !== 1'b1) begin
        busy = 0; done_pending = 0;
        continue;
      end
      exp_done = '0;
      exp_to   = 0;
      if (done_pending) exp_done = ONE << owner;
      if (expect_to && busy && (cyc - hs_cyc == TO - 1)) begin
        exp_done = ONE << owner;
        exp_to   = 1;
      end
      if (done !== '0 || exp_done != '0) check("done", done, exp_done);
      check("timeout_err", timeout_err, exp_to);
      if (exp_done != '0) busy = 0;
      check("gnt_onehot", $onehot0(gnt), 1);
      check("aw_ar_excl", axi_awvalid && axi_arvalid, 0);
      if (prev_awv && !prev_awr) begin
        check("awvalid_hold", axi_awvalid, 1);
        check("awaddr_hold", axi_awaddr, prev_awaddr);
        check("awlen_hold", axi_awlen, prev_awlen);
      end
      if (prev_arv && !prev_arr) begin
        check("arvalid_hold", axi_arvalid, 1);
        check("araddr_hold", axi_araddr, prev_araddr);
        check("arlen_hold", axi_arlen, prev_arlen);
      end
      if (axi_awvalid || axi_arvalid) check("single_burst_busy", busy, 0);
      if ((axi_awvalid && axi_awready) || (axi_arvalid && axi_arready)) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_issue: gnt=0x%0h aw=%0b addr=0x%0h with no burst expected",
                   gnt, axi_awvalid, axi_awvalid ? axi_awaddr : axi_araddr);
        end else begin
          t = exp_q.pop_front();
          check("grant", gnt, ONE << t.idx);
          check("direction_wr", axi_awvalid, t.wr);
          check("addr", axi_awvalid ? axi_awaddr : axi_araddr, t.addr);
          check("len", axi_awvalid ? axi_awlen : axi_arlen, t.len);
          owner = t.idx;
        end
        busy   = 1;
        hs_cyc = cyc;
      end
      done_pending = busy && slave_final;
      prev_awv = axi_awvalid; prev_awr = axi_awready; prev_awaddr = axi_awaddr; prev_awlen = axi_awlen;
      prev_arv = axi_arvalid; prev_arr = axi_arready; prev_araddr = axi_araddr; prev_arlen = axi_arlen;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "global timeout");
  end

  initial begin
    resetn = 0; expect_to = 0; stray = 0; no_b = 0;
    aw_lat = 0; ar_lat = 0; b_lat = 2;
    for (int i = 0; i < N; i++) begin
      p_wr[i] = 0; p_addr[i] = AW'(i * 'h1000); p_len[i] = 0; pend[i] = 1;
    end
    pend[0] = 2;
    // reset with all requesters asserting, then strict rotation 0,1,2,3,0
    push(0, 0, 'h0000, 0); push(1, 0, 'h1000, 0); push(2, 0, 'h2000, 0);
    push(3, 0, 'h3000, 0); push(0, 0, 'h0040, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {req_ready, gnt, done, axi_awvalid, axi_arvalid, timeout_err}, 0);
    resetn = 1;
    @(posedge clk);
    @(negedge clk);
    check("first_gnt", gnt, 4'b0001);
    wait_idle(500, "rotation");

    // sole persistent writer re-granted; awready next cycle, B 20 cycles later
    @(posedge clk); #1;
    aw_lat = 0; b_lat = 20;
    p_wr[0] = 1; p_addr[0] = AW'('h100); p_len[0] = 7; pend[0] = 2;
    push(0, 1, 'h100, 7); push(0, 1, 'h140, 7);
    wait_idle(500, "single_writer");

    // read len 3 from req1 blocks req2's write until the 4th beat
    @(posedge clk); #1;
    ar_lat = 1; aw_lat = 2; b_lat = 3;
    p_wr[1] = 0; p_addr[1] = AW'('h1100); p_len[1] = 3;
    p_wr[2] = 1; p_addr[2] = AW'('h2200); p_len[2] = 5;
    pend[1] = 1; pend[2] = 1;
    push(1, 0, 'h1100, 3); push(2, 1, 'h2200, 5);
    wait_idle(500, "mixed");

    // arready held low 10 cycles with stray B/R-last pulses during ISSUE
    @(posedge clk); #1;
    ar_lat = 10; stray = 1;
    p_wr[3] = 0; p_addr[3] = AW'('h3300); p_len[3] = 2; pend[3] = 1;
    push(3, 0, 'h3300, 2);
    wait_idle(500, "backpressure");
    stray = 0;

    // pointer at 3: search wraps to 0, so req1 beats req3
    @(posedge clk); #1;
    ar_lat = 0;
    p_wr[1] = 0; p_addr[1] = AW'('h1800); p_len[1] = 1;
    p_wr[3] = 0; p_addr[3] = AW'('h3800); p_len[3] = 1;
    pend[1] = 1; pend[3] = 1;
    push(1, 0, 'h1800, 1); push(3, 0, 'h3800, 1);
    wait_idle(500, "wrap");

`ifdef DDR_ARB_TIMEOUT_EN
    // bridge never answers B: watchdog aborts TO-1 cycles after the AW handshake cycle
    @(posedge clk); #1;
    aw_lat = 0; no_b = 1; expect_to = 1;
    p_wr[2] = 1; p_addr[2] = AW'('h2400); p_len[2] = 0; pend[2] = 1;
    push(2, 1, 'h2400, 0);
    wait_idle(TO + 100, "timeout");
    no_b = 0; expect_to = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
